// File: rtl/snake_segment_store.sv
// rtl/snake_segment_store.sv - circular-buffer snake body store with per-move self-collision scan
// One body compare per SCAN cycle, then a single-cycle COMMIT that pushes the new head.
module snake_segment_store #(
  parameter int COORD_BIT        = 7,
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int INIT_LENGTH      = 3,
  parameter int INIT_X           = 20,
  parameter int INIT_Y           = 15
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        game_tik,
  input  logic [COORD_BIT-1:0]        new_head_x,
  input  logic [COORD_BIT-1:0]        new_head_y,
  input  logic                        grow,
  output logic                        busy,
  output logic                        done,
  output logic                        collision,
  output logic [COORD_BIT-1:0]        snake_head_x,
  output logic [COORD_BIT-1:0]        snake_head_y,
  output logic [SNAKE_LENGTH_BIT:0]   snake_length,
  output logic                        full,
  input  logic [SNAKE_LENGTH_BIT-1:0] rd_index,
  output logic [COORD_BIT-1:0]        rd_x,
  output logic [COORD_BIT-1:0]        rd_y,
  output logic                        rd_valid
);

  localparam int MAX_LEN = 1 << SNAKE_LENGTH_BIT;
  localparam logic [SNAKE_LENGTH_BIT:0]   ONE_L = (SNAKE_LENGTH_BIT+1)'(1);
  localparam logic [SNAKE_LENGTH_BIT-1:0] ONE_P = SNAKE_LENGTH_BIT'(1);
  localparam logic [SNAKE_LENGTH_BIT:0]   MAX_L = (SNAKE_LENGTH_BIT+1)'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [COORD_BIT-1:0]        r_seg_x [MAX_LEN];
  logic [COORD_BIT-1:0]        r_seg_y [MAX_LEN];
  logic [SNAKE_LENGTH_BIT-1:0] r_head_ptr;
  logic [SNAKE_LENGTH_BIT:0]   r_length;
  logic [SNAKE_LENGTH_BIT:0]   r_limit;
  logic [SNAKE_LENGTH_BIT:0]   r_k;
  logic [COORD_BIT-1:0]        r_new_x;
  logic [COORD_BIT-1:0]        r_new_y;
  logic                        r_grow;
  logic                        r_hit;

  logic [SNAKE_LENGTH_BIT-1:0] w_scan_idx;
  logic [SNAKE_LENGTH_BIT-1:0] w_new_ptr;
  logic [SNAKE_LENGTH_BIT-1:0] w_rd_idx;
  logic                        w_match;
  logic                        w_scan_last;

  assign w_scan_idx  = r_head_ptr + r_k[SNAKE_LENGTH_BIT-1:0];
  assign w_new_ptr   = r_head_ptr - ONE_P;
  assign w_rd_idx    = r_head_ptr + rd_index;
  assign w_match     = (r_seg_x[w_scan_idx] == r_new_x) && (r_seg_y[w_scan_idx] == r_new_y);
  assign w_scan_last = (r_k == (r_limit - ONE_L));

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_COMMIT);
  assign collision    = done && r_hit;
  assign snake_head_x = r_seg_x[r_head_ptr];
  assign snake_head_y = r_seg_y[r_head_ptr];
  assign snake_length = r_length;
  assign full         = (r_length == MAX_L);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (game_tik) w_next = S_SCAN;
      S_SCAN:   if (w_scan_last) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LENGTH) begin
          r_seg_x[i] <= COORD_BIT'(INIT_X - i);
          r_seg_y[i] <= COORD_BIT'(INIT_Y);
        end else begin
          r_seg_x[i] <= '0;
          r_seg_y[i] <= '0;
        end
      end
      r_head_ptr <= '0;
      r_length   <= (SNAKE_LENGTH_BIT+1)'(INIT_LENGTH);
      r_limit    <= '0;
      r_k        <= '0;
      r_new_x    <= '0;
      r_new_y    <= '0;
      r_grow     <= 1'b0;
      r_hit      <= 1'b0;
      rd_x       <= '0;
      rd_y       <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_x     <= r_seg_x[w_rd_idx];
      rd_y     <= r_seg_y[w_rd_idx];
      rd_valid <= ({1'b0, rd_index} < r_length);
      case (r_state)
        S_IDLE: begin
          if (game_tik) begin
            r_new_x <= new_head_x;
            r_new_y <= new_head_y;
            r_grow  <= grow;
            // The tail vacates on a plain move, so it is left out of the scan.
            r_limit <= grow ? r_length : (r_length - ONE_L);
            r_hit   <= 1'b0;
            r_k     <= '0;
          end
        end
        S_SCAN: begin
          if (w_match) r_hit <= 1'b1;
          r_k <= r_k + ONE_L;
        end
        S_COMMIT: begin
          if (!r_hit) begin
            r_head_ptr          <= w_new_ptr;
            r_seg_x[w_new_ptr]  <= r_new_x;
            r_seg_y[w_new_ptr]  <= r_new_y;
            if (r_grow && !full) r_length <= r_length + ONE_L;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
